lcd_controller: RTL
===================

LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 SHALL have parameter FREQ, default 50000000, meaning CLK frequency in Hz; all delays derive from it.
REQ-002 SHALL have parameter POWERUP_MS, default 20, meaning power-on wait before the first LCD access.
REQ-003 SHALL provide ports:
- CLK  in  1  clock, sole clock domain.
- RESET_N  in  1  reset; asynchronous assert, active-low.
- wr_valid  in  1  host byte request.
- wr_ready  out  1  controller can accept a byte.
- wr_data  in  8  byte to write.
- wr_rs  in  1  0 = instruction, 1 = data.
- init_done  out  1  init sequence complete; stays high until reset.
- xfer_send  out  1  one-cycle start pulse to the nibble transfer engine.
- xfer_command  out  4  nibble to transfer.
- xfer_rs  out  1  RS for the nibble.
- xfer_read_busy  out  1  engine polls the busy flag after the nibble.
- xfer_mode4bit  out  1  engine reads busy as two nibbles.
- xfer_done  in  1  engine completion pulse.

Function
REQ-004 SHALL run the states POWERUP, INIT_NIB, INIT_WAIT, INIT_BYTE, IDLE, HI_SEND, HI_WAIT, LO_SEND, LO_WAIT, GAP.
REQ-005 POWERUP SHALL count FREQ/1000*POWERUP_MS cycles, then go to INIT_NIB.
REQ-006 Init nibble phase, in order:
- nibbles 0x3, 0x3, 0x3, 0x2, all rs=0, read_busy=0, mode4bit=0.
- each is followed by an INIT_WAIT of 5 ms, 200 us, 200 us and 200 us respectively.
REQ-007 Init byte phase:
- INIT_BYTE SHALL then issue bytes 0x28, 0x0C, 0x01, 0x06 (rs=0) through the byte path of REQ-009.
- init_done SHALL rise the cycle after the last byte completes, with the state entering IDLE in the same cycle.
REQ-008 wr_ready SHALL be 1 only in IDLE with init_done=1.
- A byte is accepted on the cycle with wr_valid and wr_ready both high; wr_data and wr_rs are latched at that edge.
- wr_ready SHALL drop the following cycle.
REQ-009 Byte path:
- HI_SEND SHALL issue the high nibble with read_busy=0, mode4bit=1.
- HI_WAIT SHALL wait for xfer_done, then pass through GAP.
- LO_SEND SHALL issue the low nibble with mode4bit=1 and read_busy per REQ-017.
- LO_WAIT SHALL wait for xfer_done, then pass through GAP, then return to IDLE (or to the next init byte).
REQ-010 xfer_send timing:
- xfer_send SHALL be a single-cycle pulse.
- xfer_command, xfer_rs, xfer_read_busy and xfer_mode4bit SHALL be valid in the pulse cycle and held until xfer_done.
REQ-011 After each xfer_done, GAP SHALL last exactly 2 cycles before the next xfer_send, so the engine has returned to its idle state.
REQ-012 Earliest accept-to-send latency: xfer_send for the high nibble SHALL assert 1 cycle after acceptance.
REQ-013 xfer_done SHALL be ignored outside HI_WAIT, LO_WAIT and the INIT_NIB wait, and SHALL NOT cause a state change there.
REQ-014 wr_valid SHALL have no effect while wr_ready=0; no byte is queued.
REQ-015 Delay counters SHALL be 24 bits wide, load terminal count minus 1, count down to 0, and SHALL NOT wrap.

Reset
REQ-016 While RESET_N=0:
- all outputs SHALL be 0, the state SHALL be POWERUP, and counters SHALL be cleared.
- deassertion mid-transfer SHALL restart the full power-up and init sequence; no partial byte is resumed.

Configuration
REQ-017 Macro LCD_BUSY_POLL_EN:
- Defined: the low nibble (and every init byte's low nibble) SHALL use xfer_read_busy=1, and GAP is the only post-byte wait.
- Undefined: xfer_read_busy SHALL be 0 always, and LO_WAIT SHALL add a fixed wait of 2 ms after instruction bytes 0x01/0x02/0x03 and 50 us after all others.

Structure
REQ-018 Package lcd_pkg SHALL hold:
- the controller state enum;
- the init nibble and init byte tables with their per-entry delays;
- the timing constants as functions of FREQ.
REQ-019 Sub-module lcd_delay_timer (load, count, expire pulse) SHALL implement every timed wait; there is exactly one instance.

Verification
REQ-020 The bench SHALL use FREQ=1000000, POWERUP_MS=1, and a behavioural engine that returns xfer_done 10 cycles after xfer_send. Scenarios:
- Reset release -> 1000 cycles idle, then nibbles 3,3,3,2 spaced by 5000/200/200/200-cycle waits, then init bytes 28,0C,01,06, then init_done=1.
- After init, write 0x41 with rs=1 -> xfer_command 0x4 then 0x1, xfer_rs=1 on both, wr_ready low until the return to IDLE.
- wr_valid held high for 3 bytes -> exactly 3 bytes transferred, with no xfer_send closer than 2 cycles after an xfer_done.
- Spurious xfer_done in IDLE -> no state change and no xfer_send.
- RESET_N pulsed low during LO_WAIT -> all outputs 0 and init_done=0, then the full init sequence repeats.
- Without LCD_BUSY_POLL_EN, write 0x01 -> xfer_read_busy=0 and a 2000-cycle wait before wr_ready returns high.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, init tables and timing helpers for the HD44780-style LCD controller.
// Optional busy-flag polling is selected by the LCD_BUSY_POLL_EN macro (see lcd_controller).
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_POWERUP,
        ST_INIT_NIB,
        ST_INIT_WAIT,
        ST_INIT_BYTE,
        ST_IDLE,
        ST_HI_SEND,
        ST_HI_WAIT,
        ST_LO_SEND,
        ST_LO_WAIT,
        ST_GAP
    } lcd_state_e;

    localparam int unsigned TIMER_W    = 24;
    localparam int unsigned INIT_STEPS = 4;

    // Wake-up nibbles in 8-bit mode, then the switch to 4-bit mode.
    localparam logic [3:0]  INIT_NIBBLE         [INIT_STEPS] = '{4'h3, 4'h3, 4'h3, 4'h2};
    localparam int unsigned INIT_NIBBLE_WAIT_US [INIT_STEPS] = '{5000, 200, 200, 200};

    // Function set, display on, clear, entry mode.
    localparam logic [7:0]  INIT_BYTE           [INIT_STEPS] = '{8'h28, 8'h0C, 8'h01, 8'h06};
    localparam int unsigned INIT_BYTE_WAIT_US   [INIT_STEPS] = '{50, 50, 2000, 50};

    localparam int unsigned SLOW_INSTR_US = 2000;
    localparam int unsigned FAST_INSTR_US = 50;
    localparam int unsigned GAP_CYCLES    = 2;

    function automatic logic [TIMER_W-1:0] ms_to_cycles(input int unsigned freq,
                                                        input int unsigned ms);
        return TIMER_W'((freq / 1000) * ms);
    endfunction

    function automatic logic [TIMER_W-1:0] us_to_cycles(input int unsigned freq,
                                                        input int unsigned us);
        return TIMER_W'((freq / 1000) * us / 1000);
    endfunction

    // Clear and return-home instructions need the long execution time.
    function automatic logic is_slow_instr(input logic [7:0] data, input logic rs);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counting delay timer: load a terminal count, pulse expire in the N-th cycle after load.
// Never wraps; it idles once the count reaches zero.
module lcd_delay_timer
    import lcd_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               load,
    input  logic [TIMER_W-1:0] terminal,
    output logic               busy,
    output logic               expire
);

    logic [TIMER_W-1:0] count_q;
    logic               active_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            count_q  <= (terminal == '0) ? '0 : terminal - TIMER_W'(1);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (count_q == '0)
                active_q <= 1'b0;
            else
                count_q <= count_q - TIMER_W'(1);
        end
    end

    assign busy   = active_q;
    assign expire = active_q && (count_q == '0);

endmodule

// File: rtl/lcd_controller.sv
// LCD controller: power-up wait, 4-bit init sequence, then host bytes split into two nibbles.
// LCD_BUSY_POLL_EN: poll the busy flag after each low nibble instead of fixed execution waits.
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int unsigned FREQ       = 50000000,
    parameter int unsigned POWERUP_MS = 20
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    input  logic       wr_rs,
    output logic       init_done,
    output logic       xfer_send,
    output logic [3:0] xfer_command,
    output logic       xfer_rs,
    output logic       xfer_read_busy,
    output logic       xfer_mode4bit,
    input  logic       xfer_done
);

    localparam logic [TIMER_W-1:0] POWERUP_CYC = ms_to_cycles(FREQ, POWERUP_MS);
    localparam logic [TIMER_W-1:0] GAP_CYC     = TIMER_W'(GAP_CYCLES);
    localparam logic [TIMER_W-1:0] NIB_WAIT_CYC [INIT_STEPS] = '{
        us_to_cycles(FREQ, INIT_NIBBLE_WAIT_US[0]), us_to_cycles(FREQ, INIT_NIBBLE_WAIT_US[1]),
        us_to_cycles(FREQ, INIT_NIBBLE_WAIT_US[2]), us_to_cycles(FREQ, INIT_NIBBLE_WAIT_US[3])};

`ifdef LCD_BUSY_POLL_EN
    localparam logic LO_READ_BUSY = 1'b1;
`else
    localparam logic LO_READ_BUSY = 1'b0;
    localparam logic [TIMER_W-1:0] SLOW_CYC = us_to_cycles(FREQ, SLOW_INSTR_US);
    localparam logic [TIMER_W-1:0] FAST_CYC = us_to_cycles(FREQ, FAST_INSTR_US);
    localparam logic [TIMER_W-1:0] BYTE_WAIT_CYC [INIT_STEPS] = '{
        us_to_cycles(FREQ, INIT_BYTE_WAIT_US[0]), us_to_cycles(FREQ, INIT_BYTE_WAIT_US[1]),
        us_to_cycles(FREQ, INIT_BYTE_WAIT_US[2]), us_to_cycles(FREQ, INIT_BYTE_WAIT_US[3])};
`endif

    lcd_state_e         state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic               rs_q, rs_d;
    logic [1:0]         nib_idx_q, nib_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic               init_done_q, init_done_d;
    logic               sub_q, sub_d;       // nibble issued (INIT_NIB) / done seen (LO_WAIT)
    logic               gap_lo_q, gap_lo_d; // GAP leads to the low nibble rather than byte end
    logic               tmr_load, tmr_busy, tmr_expire;
    logic [TIMER_W-1:0] tmr_terminal;

    lcd_delay_timer u_timer (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .load     (tmr_load),
        .terminal (tmr_terminal),
        .busy     (tmr_busy),
        .expire   (tmr_expire)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_POWERUP;
            data_q      <= '0;
            rs_q        <= 1'b0;
            nib_idx_q   <= '0;
            byte_idx_q  <= '0;
            init_done_q <= 1'b0;
            sub_q       <= 1'b0;
            gap_lo_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            nib_idx_q   <= nib_idx_d;
            byte_idx_q  <= byte_idx_d;
            init_done_q <= init_done_d;
            sub_q       <= sub_d;
            gap_lo_q    <= gap_lo_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        rs_d           = rs_q;
        nib_idx_d      = nib_idx_q;
        byte_idx_d     = byte_idx_q;
        init_done_d    = init_done_q;
        sub_d          = sub_q;
        gap_lo_d       = gap_lo_q;
        tmr_load       = 1'b0;
        tmr_terminal   = GAP_CYC;
        wr_ready       = 1'b0;
        xfer_send      = 1'b0;
        xfer_command   = 4'h0;
        xfer_rs        = 1'b0;
        xfer_read_busy = 1'b0;
        xfer_mode4bit  = 1'b0;

        case (state_q)
            ST_POWERUP: begin
                if (tmr_expire) begin
                    state_d = ST_INIT_NIB;
                end else if (!tmr_busy) begin
                    tmr_load     = 1'b1;
                    tmr_terminal = POWERUP_CYC;
                end
            end
            ST_INIT_NIB: begin
                xfer_command = INIT_NIBBLE[nib_idx_q];
                if (!sub_q) begin
                    xfer_send = 1'b1;
                    sub_d     = 1'b1;
                end else if (xfer_done) begin
                    sub_d        = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_terminal = NIB_WAIT_CYC[nib_idx_q];
                    state_d      = ST_INIT_WAIT;
                end
            end
            ST_INIT_WAIT: begin
                if (tmr_expire) begin
                    if (nib_idx_q == 2'd3) begin
                        nib_idx_d = '0;
                        state_d   = ST_INIT_BYTE;
                    end else begin
                        nib_idx_d = nib_idx_q + 2'd1;
                        state_d   = ST_INIT_NIB;
                    end
                end
            end
            ST_INIT_BYTE: begin
                data_d  = INIT_BYTE[byte_idx_q];
                rs_d    = 1'b0;
                state_d = ST_HI_SEND;
            end
            ST_IDLE: begin
                wr_ready = init_done_q;
                if (wr_valid && init_done_q) begin
                    data_d  = wr_data;
                    rs_d    = wr_rs;
                    state_d = ST_HI_SEND;
                end
            end
            ST_HI_SEND, ST_HI_WAIT: begin
                xfer_send     = (state_q == ST_HI_SEND);
                xfer_command  = data_q[7:4];
                xfer_rs       = rs_q;
                xfer_mode4bit = 1'b1;
                if (state_q == ST_HI_SEND) begin
                    state_d = ST_HI_WAIT;
                end else if (xfer_done) begin
                    tmr_load = 1'b1;
                    gap_lo_d = 1'b1;
                    state_d  = ST_GAP;
                end
            end
            ST_LO_SEND: begin
                xfer_send      = 1'b1;
                xfer_command   = data_q[3:0];
                xfer_rs        = rs_q;
                xfer_read_busy = LO_READ_BUSY;
                xfer_mode4bit  = 1'b1;
                state_d        = ST_LO_WAIT;
            end
            ST_LO_WAIT: begin
                xfer_command   = data_q[3:0];
                xfer_rs        = rs_q;
                xfer_read_busy = LO_READ_BUSY;
                xfer_mode4bit  = 1'b1;
`ifdef LCD_BUSY_POLL_EN
                if (xfer_done) begin
                    tmr_load = 1'b1;
                    gap_lo_d = 1'b0;
                    state_d  = ST_GAP;
                end
`else
                // Fixed execution time follows the transfer, then the usual gap.
                if (!sub_q) begin
                    if (xfer_done) begin
                        sub_d    = 1'b1;
                        tmr_load = 1'b1;
                        if (!init_done_q)
                            tmr_terminal = BYTE_WAIT_CYC[byte_idx_q];
                        else if (is_slow_instr(data_q, rs_q))
                            tmr_terminal = SLOW_CYC;
                        else
                            tmr_terminal = FAST_CYC;
                    end
                end else if (tmr_expire) begin
                    sub_d    = 1'b0;
                    tmr_load = 1'b1;
                    gap_lo_d = 1'b0;
                    state_d  = ST_GAP;
                end
`endif
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    if (gap_lo_q) begin
                        state_d = ST_LO_SEND;
                    end else if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (byte_idx_q == 2'd3) begin
                        byte_idx_d  = '0;
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = ST_INIT_BYTE;
                    end
                end
            end
            default: state_d = ST_POWERUP;
        endcase
    end

    assign init_done = init_done_q;

endmodule
